pipe_trace_capture: RTL

Synthesizable, parametrised trace capture unit for the pipelined CPU. It samples up to NUM_CH pipeline-buffer probe buses every enabled clock into a circular trace RAM, stamping each sample with a free-running cycle count. It stops after a programmable trigger plus a fixed number of post-trigger samples, then streams the stored samples out oldest-first over a valid/ready port. It sits beside the CPU core, with probes tapped from the IF/ID, ID/EX, EX/MEM and MEM/WB buffers.

---
 rtl/pipe_trace_pkg.sv | 22 ++
 rtl/pipe_trace_capture_ram.sv | 32 +++
 rtl/pipe_trace_capture.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipe_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_pkg
//  Description : Shared state encoding and entry-width helper for the
//                pipeline trace capture unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_trace_pkg;

   // Capture state machine encoding, also exported on the state port
   localparam logic [1:0] c_st_idle     = 2'd0;
   localparam logic [1:0] c_st_pretrig  = 2'd1;
   localparam logic [1:0] c_st_posttrig = 2'd2;
   localparam logic [1:0] c_st_done     = 2'd3;

   // One trace entry is {cycle_stamp, probe bus}
   function automatic int entry_w(input int num_ch, input int ch_w, input int cnt_w);
      return cnt_w + num_ch * ch_w;
   endfunction

endpackage : pipe_trace_pkg
`default_nettype wire

// File: rtl/pipe_trace_capture_ram.sv
`default_nettype none
// ============================================================================
//  Module      : trace_ram
//  Description : DEPTH x WIDTH trace storage, one synchronous write port and
//                one asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_ram #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 80
) (
   input  logic                     clock,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Store one entry per enabled write
   always_ff @(posedge clock) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule : trace_ram
`default_nettype wire

// File: rtl/pipe_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_capture
//  Description : Samples pipeline probe buses into a circular trace RAM with
//                cycle stamps, stops a fixed number of samples after a
//                trigger, then streams entries out oldest-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_capture
   import pipe_trace_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CH_W      = 16,
   parameter int DEPTH     = 8,
   parameter int CNT_W     = 16,
   parameter int POST_TRIG = 3
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             sample_en,
   input  logic [NUM_CH*CH_W-1:0]           probe,
   input  logic                             arm,
   input  logic                             force_trig,
   input  logic [$clog2(NUM_CH)-1:0]        trig_ch,
   input  logic [CH_W-1:0]                  trig_value,
   input  logic [CH_W-1:0]                  trig_mask,
   input  logic                             rd_ready,
   output logic                             rd_valid,
   output logic [CNT_W+NUM_CH*CH_W-1:0]     rd_data,
   output logic [1:0]                       state,
   output logic [$clog2(DEPTH):0]           fill,
   output logic [$clog2(DEPTH)-1:0]         trig_pos
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_fw = c_aw + 1;
   localparam int c_ew = entry_w(NUM_CH, CH_W, CNT_W);

   localparam logic [c_fw-1:0] c_depth = c_fw'(DEPTH);
   localparam logic [c_aw-1:0] c_post  = c_aw'(POST_TRIG);

   logic [1:0]       r_state;
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_fw-1:0]  r_fill;
   logic [c_fw-1:0]  r_rd_cnt;
   logic [c_aw-1:0]  r_post_cnt;
   logic [CNT_W-1:0] r_cycle_cnt;

   logic [CH_W-1:0]  w_trig_data;
   logic             w_match;
   logic             w_trig;
   logic             w_capture;
   logic             w_wr_en;
   logic [c_aw-1:0]  w_rd_addr;
   logic [c_ew-1:0]  w_ram_q;
   logic             w_rd_valid;
   logic [c_fw-1:0]  w_fill_next;

   // Select the channel watched by the trigger comparator
   always_comb begin
      w_trig_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (int'(trig_ch) == k) begin
            w_trig_data = probe[k*CH_W +: CH_W];
         end
      end
   end

   assign w_match   = ((w_trig_data ^ trig_value) & trig_mask) == '0;
   assign w_trig    = sample_en & (w_match | force_trig);
   assign w_capture = (r_state == c_st_pretrig) || (r_state == c_st_posttrig);
   // arm takes priority, so the sample of an arm cycle is dropped
   assign w_wr_en   = sample_en & w_capture & ~arm;

   // Fill saturates once the circular buffer has wrapped
   assign w_fill_next = (r_fill == c_depth) ? r_fill : r_fill + c_fw'(1);

   // Oldest entry sits fill positions behind the write pointer (mod DEPTH)
   assign w_rd_addr  = r_wr_ptr - r_fill[c_aw-1:0] + r_rd_cnt[c_aw-1:0];
   assign w_rd_valid = (r_state == c_st_done) && (r_rd_cnt != r_fill);

   assign rd_valid = w_rd_valid;
   assign rd_data  = w_rd_valid ? w_ram_q : '0;
   assign state    = r_state;
   assign fill     = r_fill;
   assign trig_pos = (r_state == c_st_done) ? (r_fill[c_aw-1:0] - c_aw'(1) - c_post) : '0;

   // Capture FSM, pointers and free-running cycle stamp
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= c_st_idle;
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_rd_cnt    <= '0;
         r_post_cnt  <= '0;
         r_cycle_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (arm) begin
            r_state    <= c_st_pretrig;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_rd_cnt   <= '0;
            r_post_cnt <= '0;
         end else begin
            case (r_state)
               c_st_pretrig: begin
                  if (sample_en) begin
                     r_wr_ptr <= r_wr_ptr + c_aw'(1);
                     r_fill   <= w_fill_next;
                     if (w_trig) begin
                        if (POST_TRIG == 0) begin
                           r_state <= c_st_done;
                        end else begin
                           r_post_cnt <= c_post;
                           r_state    <= c_st_posttrig;
                        end
                     end
                  end
               end
               c_st_posttrig: begin
                  if (sample_en) begin
                     r_wr_ptr   <= r_wr_ptr + c_aw'(1);
                     r_fill     <= w_fill_next;
                     r_post_cnt <= r_post_cnt - c_aw'(1);
                     if (r_post_cnt == c_aw'(1)) begin
                        r_state <= c_st_done;
                     end
                  end
               end
               c_st_done: begin
                  if (w_rd_valid && rd_ready) begin
                     r_rd_cnt <= r_rd_cnt + c_fw'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (c_ew)
   ) u_trace_ram (
      .clock   (clock),
      .wr_en   (w_wr_en),
      .wr_addr (r_wr_ptr),
      .wr_data ({r_cycle_cnt, probe}),
      .rd_addr (w_rd_addr),
      .rd_data (w_ram_q)
   );

endmodule : pipe_trace_capture
`default_nettype wire
